// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/half/word data-memory access stage with req/ack handshake
// Ports: start/is_store/size/sign_ext/addr/store_data request in; mem_req/mem_we/mem_addr/
// mem_be/mem_wdata to memory, mem_ack/mem_rdata back; mem_read_data extended load result;
// busy/done status; misalign_err/timeout_err sticky until the next accepted start.
module load_store_unit #(
   parameter int DataSize      = 32,
   parameter int TimeoutCycles = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                is_store,
   input  logic [1:0]          size,
   input  logic                sign_ext,
   input  logic [DataSize-1:0] addr,
   input  logic [DataSize-1:0] store_data,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DataSize-1:0] mem_addr,
   output logic [3:0]          mem_be,
   output logic [DataSize-1:0] mem_wdata,
   input  logic                mem_ack,
   input  logic [DataSize-1:0] mem_rdata,
   output logic [DataSize-1:0] mem_read_data,
   output logic                busy,
   output logic                done,
   output logic                misalign_err,
   output logic                timeout_err
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] size_q, size_d, off_q, off_d;
   logic sign_q, sign_d;
   logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d;
   logic misalign_q, misalign_d, timeout_q, timeout_d;
   logic [3:0] mem_be_q, mem_be_d;
   logic [DataSize-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
   logic [DataSize-1:0] shifted, load_ext;
   logic mis;
   // halfword offsets are 0 or 2, so one shift by the lane index serves both sizes
   assign shifted  = mem_rdata >> {off_q, 3'b000};
   assign load_ext = size_q == 2'b00 ? {{24{sign_q & shifted[7]}}, shifted[7:0]} :
                     size_q == 2'b01 ? {{16{sign_q & shifted[15]}}, shifted[15:0]} : shifted;
   assign mis = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      off_d       = off_q;
      sign_d      = sign_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      misalign_d  = misalign_q;
      timeout_d   = timeout_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            size_d     = size;
            sign_d     = sign_ext;
            off_d      = addr[1:0];
            cnt_d      = 8'd0;
            misalign_d = mis;
            timeout_d  = 1'b0;
            if (mis) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d     = ACCESS;
               mem_req_d   = 1'b1;
               mem_we_d    = is_store;
               mem_addr_d  = {addr[DataSize-1:2], 2'b00};
               mem_be_d    = size == 2'b00 ? 4'b0001 << addr[1:0] :
                             size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
               mem_wdata_d = size == 2'b00 ? {4{store_data[7:0]}} :
                             size == 2'b01 ? {2{store_data[15:0]}} : store_data;
            end
         end
         ACCESS: if (mem_ack) begin
            state_d   = DONE;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
            rdata_d   = mem_we_q ? rdata_q : load_ext;
         end else if (cnt_q + 8'd1 == 8'(TimeoutCycles)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
            timeout_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         size_q      <= '0;
         off_q       <= '0;
         sign_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         off_q       <= off_d;
         sign_q      <= sign_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         misalign_q  <= misalign_d;
         timeout_q   <= timeout_d;
      end
   end
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_be        = mem_be_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_read_data = rdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign misalign_err  = misalign_q;
   assign timeout_err   = timeout_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven, hand-sequenced and randomized checks of load_store_unit
module tb_load_store_unit;
   localparam int T = 4;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, is_store = 1'b0, sign_ext = 1'b0, mem_ack = 1'b0;
   logic [1:0] size = 2'b00;
   logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
   logic mem_req, mem_we, busy, done, misalign_err, timeout_err;
   logic [3:0] mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_read_data;
   int errors = 0, checks = 0;
   logic [31:0] model_rd = '0;

   load_store_unit #(.DataSize(32), .TimeoutCycles(T)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
      .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_read_data(mem_read_data),
      .busy(busy), .done(done), .misalign_err(misalign_err), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] addr, sd;
      int          ack;
      logic [31:0] rd;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      int          e_done;
      logic        e_mis, e_to;
      logic [31:0] e_rd;
      int          e_req;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic st, logic [1:0] sz, logic sx, logic [31:0] a, logic [31:0] sd,
                               int ack, logic [31:0] rd, logic [3:0] e_be, logic [31:0] e_wdata,
                               int e_done, logic e_mis, logic e_to, logic [31:0] e_rd, int e_req);
      vec_t v;
      v.st = st; v.sz = sz; v.sx = sx; v.addr = a; v.sd = sd; v.ack = ack; v.rd = rd;
      v.e_be = e_be; v.e_wdata = e_wdata; v.e_done = e_done; v.e_mis = e_mis; v.e_to = e_to;
      v.e_rd = e_rd; v.e_req = e_req;
      return v;
   endfunction

   // Reference: expected results derived from access size, lane offset and ack timing
   function automatic vec_t model(vec_t v, logic [31:0] prev_rd);
      int nb, off;
      logic acked;
      logic [31:0] mask, val;
      nb = v.sz == 2'd0 ? 1 : v.sz == 2'd1 ? 2 : 4;
      off = int'(v.addr[1:0]);
      v.e_mis = v.sz == 2'd3 || (off % nb) != 0;
      v.e_be = 4'(((1 << nb) - 1) << off);
      for (int k = 0; k < 4; k++) v.e_wdata[8*k +: 8] = v.sd[8*(k % nb) +: 8];
      acked = v.ack >= 1 && v.ack <= T;
      v.e_done = v.e_mis ? 1 : acked ? v.ack + 1 : T + 1;
      v.e_to = !v.e_mis && !acked;
      v.e_req = v.e_mis ? 0 : acked ? v.ack : T;
      v.e_rd = prev_rd;
      if (!v.e_mis && acked && !v.st) begin
         mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8*nb)) - 32'd1;
         val = (v.rd >> (8*off)) & mask;
         if (v.sx && nb < 4 && val[8*nb-1]) val = val | ~mask;
         v.e_rd = val;
      end
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      int cyc, dcyc, reqn;
      logic [3:0] be1;
      logic [31:0] a1, w1;
      logic we1;
      is_store = v.st; size = v.sz; sign_ext = v.sx; addr = v.addr; store_data = v.sd;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1; dcyc = 0; reqn = 0;
      be1 = mem_be; a1 = mem_addr; w1 = mem_wdata; we1 = mem_we;
      while (dcyc == 0 && cyc < 64) begin
         if (mem_req) reqn++;
         if (done) dcyc = cyc;
         else begin
            mem_ack = cyc == v.ack;
            mem_rdata = mem_ack ? v.rd : $urandom;
            tick();
            mem_ack = 1'b0;
            cyc++;
         end
      end
      chk({tag, " done_cycle"}, 32'(dcyc), 32'(v.e_done));
      chk({tag, " misalign_err"}, 32'(misalign_err), 32'(v.e_mis));
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'(v.e_to));
      chk({tag, " mem_read_data"}, mem_read_data, v.e_rd);
      chk({tag, " req_cycles"}, 32'(reqn), 32'(v.e_req));
      chk({tag, " busy_in_done"}, 32'(busy), 32'(dcyc != 0));
      if (!v.e_mis) begin
         chk({tag, " mem_be"}, 32'(be1), 32'(v.e_be));
         chk({tag, " mem_addr"}, a1, v.addr & 32'hFFFF_FFFC);
         chk({tag, " mem_we"}, 32'(we1), 32'(v.st));
         if (v.st) chk({tag, " mem_wdata"}, w1, v.e_wdata);
      end
      tick();
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
      chk({tag, " err_sticky"}, 32'({misalign_err, timeout_err}), 32'({v.e_mis, v.e_to}));
   endtask

   initial begin
      vec_t tbl[11];
      vec_t v;
      int dn, rq, we;
      tbl[0]  = mk(0, 0, 1, 32'h103, 0, 1, 32'h80FF_1234, 4'b1000, 0, 2, 0, 0, 32'hFFFF_FF80, 1);
      tbl[1]  = mk(0, 0, 0, 32'h103, 0, 1, 32'h80FF_1234, 4'b1000, 0, 2, 0, 0, 32'h0000_0080, 1);
      tbl[2]  = mk(1, 1, 0, 32'h22, 32'hDEAD_BEEF, 4, 0, 4'b1100, 32'hBEEF_BEEF, 5, 0, 0, 32'h80, 4);
      tbl[3]  = mk(0, 2, 0, 32'h06, 0, 1, 32'h5555_5555, 4'b0000, 0, 1, 1, 0, 32'h80, 0);
      tbl[4]  = mk(0, 2, 0, 32'h08, 0, 2, 32'h1234_5678, 4'b1111, 0, 3, 0, 0, 32'h1234_5678, 2);
      tbl[5]  = mk(0, 1, 1, 32'h02, 0, 0, 32'hFFFF_FFFF, 4'b1100, 0, 5, 0, 1, 32'h1234_5678, 4);
      tbl[6]  = mk(0, 1, 1, 32'h02, 0, 4, 32'h8001_0000, 4'b1100, 0, 5, 0, 0, 32'hFFFF_8001, 4);
      tbl[7]  = mk(0, 0, 0, 32'h01, 0, 3, 32'h0000_AB00, 4'b0010, 0, 4, 0, 0, 32'h0000_00AB, 3);
      tbl[8]  = mk(1, 3, 0, 32'h00, 32'h1111_1111, 1, 0, 4'b0000, 0, 1, 1, 0, 32'hAB, 0);
      tbl[9]  = mk(0, 1, 0, 32'h01, 0, 1, 32'hFFFF_FFFF, 4'b0000, 0, 1, 1, 0, 32'hAB, 0);
      tbl[10] = mk(1, 0, 0, 32'h13, 32'h0000_005A, 1, 0, 4'b1000, 32'h5A5A_5A5A, 2, 0, 0, 32'hAB, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("reset outputs", {mem_req, mem_we, busy, done, misalign_err, timeout_err, mem_be},
          32'd0);
      chk("reset mem_read_data", mem_read_data, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // start pulses in ACCESS and DONE must neither restart nor queue an access
      is_store = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h40;
      start = 1'b1;
      tick();
      start = 1'b0; is_store = 1'b1; addr = 32'h80;
      dn = 0; rq = 0; we = 0;
      for (int c = 1; c <= 12; c++) begin
         if (done) dn++;
         if (mem_req) rq++;
         if (mem_we) we++;
         start = c == 2 || c == 4;
         mem_ack = c == 3;
         mem_rdata = mem_ack ? 32'h1357_2468 : 32'hFFFF_FFFF;
         tick();
      end
      start = 1'b0; mem_ack = 1'b0;
      chk("ignored_start done_count", 32'(dn), 32'd1);
      chk("ignored_start req_cycles", 32'(rq), 32'd3);
      chk("ignored_start store_seen", 32'(we), 32'd0);
      chk("ignored_start read_data", mem_read_data, 32'h1357_2468);

      // asynchronous reset in the middle of a pending load
      is_store = 1'b0; size = 2'd2; addr = 32'h0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("pre_reset mem_req", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_reset mem_req", 32'(mem_req), 32'd0);
      chk("async_reset busy", 32'(busy), 32'd0);
      chk("async_reset read_data", mem_read_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      mem_ack = 1'b0;
      chk("late_ack read_data", mem_read_data, 32'd0);
      chk("late_ack done", 32'(done), 32'd0);
      chk("late_ack busy_req", 32'({busy, mem_req}), 32'd0);
      model_rd = 32'd0;

      for (int i = 0; i < 150; i++) begin
         v.st = 1'($urandom);
         v.sz = 2'($urandom_range(0, 3));
         v.sx = 1'($urandom);
         v.addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC) | (v.sz == 0 ? 32'($urandom_range(0, 3)) : 32'd0);
         v.sd = $urandom;
         v.ack = $urandom_range(0, 6);
         v.rd = $urandom;
         v = model(v, model_rd);
         model_rd = v.e_rd;
         apply(v, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage for the TiniSOC core. It sits directly upstream of the write-back mux stage and produces the `mem_read_data` word that stage selects when `write_reg_select = 2'b10`. It accepts one byte, halfword or word load/store request at a time, runs a req/ack handshake with data memory, and handles byte lanes and sign/zero extension. Misaligned accesses and memory timeouts are reported as errors.

## Interface
- `DataSize`, 32: data and address width (fixed at 32; byte-lane logic assumes 4 lanes)
- `TimeoutCycles`, 16: number of ACCESS cycles without `mem_ack` before a timeout is declared; legal range 1..255

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- `sign_ext`  in  1  loads only: 1 sign-extends, 0 zero-extends
- `addr`  in  DataSize  byte address
- `store_data`  in  DataSize  register operand (read_data2); low byte/half/word is stored
- `mem_req`  out  1  memory request; held until ack or timeout
- `mem_we`  out  1  write enable, valid with `mem_req`
- `mem_addr`  out  DataSize  word address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables, bit k = lane k
- `mem_wdata`  out  DataSize  write data, replicated across lanes
- `mem_ack`  in  1  memory completion; load data valid on `mem_rdata` in the same cycle
- `mem_rdata`  in  DataSize  memory read word
- `mem_read_data`  out  DataSize  extended load result, feeds write-back mux
- `busy`  out  1  high in ACCESS and DONE
- `done`  out  1  one-cycle completion pulse
- `misalign_err`  out  1  sticky until the next accepted `start`
- `timeout_err`  out  1  sticky until the next accepted `start`

## Operation
- FSM states are IDLE, ACCESS and DONE. All outputs are registered.
- **IDLE, `start` = 1:** latch `is_store`, `size`, `sign_ext`, `addr[1:0]` and `store_data`; clear both error flags.
  - Misaligned request (half with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, or `size` = 11): go to DONE with `misalign_err` = 1. No `mem_req` is issued.
  - Otherwise go to ACCESS with `mem_req` = 1 and `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` driven.
- **Byte lanes (little-endian):** lane k = bits [8k+7:8k] and k = `addr[1:0]`.
  - byte: `mem_be` = 1<<k, `mem_wdata` = {4{sd[7:0]}}
  - half: `mem_be` = 0011 or 1100, `mem_wdata` = {2{sd[15:0]}}
  - word: `mem_be` = 1111, `mem_wdata` = sd
  - For loads, `mem_be` has the same pattern.
- **ACCESS:** the wait counter increments on each cycle with `mem_ack` = 0.
  - `mem_ack` = 1: a load registers the extracted lane into `mem_read_data` (extended to 32 bits per `sign_ext`); go to DONE.
  - Counter reaches `TimeoutCycles` with no ack: set `timeout_err`, leave `mem_read_data` unchanged, go to DONE.
  - `mem_req` deasserts on leaving ACCESS.
- **DONE:** `done` = 1 for exactly one cycle, then return to IDLE. `start` in ACCESS or DONE is ignored and not queued.
- **`mem_read_data`** holds its value until the next successful load. Stores and failed accesses never modify it.
- **Reset values:** all outputs are 0, the FSM is in IDLE, and the counter is 0.

## Timing
- `start` sampled in cycle 0, so `mem_req` is high from cycle 1.
- Ack sampled in cycle n (n ≥ 1): `done` and valid `mem_read_data` in cycle n+1, and `mem_req` is low in cycle n+1.
- Zero-wait memory (ack in cycle 1) gives `done` in cycle 2, so minimum back-to-back issue is 3 cycles per access (next `start` accepted in cycle 3).
- Timeout: no ack in cycles 1..T (T = `TimeoutCycles`) gives `done` and `timeout_err` in cycle T+1. An ack in cycle T still completes normally.
- Misaligned request: `done` and `misalign_err` in cycle 1, with no `mem_req` pulse.
- Reset asserted mid-ACCESS drops `mem_req` and `busy` immediately (asynchronously). A later ack is ignored.
- `mem_rdata` is sampled only in the ack cycle.

## Test plan
- **Byte load, sign-extended:** load byte, `sign_ext` = 1, addr 0x103, `mem_rdata` = 0x80FF_1234, ack in cycle 1 → `mem_be` = 1000, `mem_addr` = 0x100, `mem_read_data` = 0xFFFF_FF80 with `done` in cycle 2. Repeat with `sign_ext` = 0 → 0x0000_0080.
- **Halfword store with wait states:** store half, addr 0x22, `store_data` = 0xDEAD_BEEF, ack in cycle 4 → `mem_we` = 1, `mem_be` = 1100, `mem_wdata` = 0xBEEF_BEEF, `mem_req` high for cycles 1-4, `done` in cycle 5, `mem_read_data` unchanged.
- **Misaligned word:** word load at addr 0x06 → no `mem_req`, `done` and `misalign_err` in cycle 1. The next aligned `start` clears `misalign_err`.
- **Timeout:** `TimeoutCycles` = 4, ack never asserted → `mem_req` high in cycles 1-4, `done` and `timeout_err` in cycle 5, `mem_read_data` unchanged. A second run with ack in cycle 4 completes without error.
- **Ignored start and reset mid-access:** `start` pulsed during ACCESS → ignored, exactly one `done`. Assert `rst` low in cycle 2 of a pending load → `mem_req`, `busy` and `mem_read_data` = 0 immediately; a late ack after release has no effect.
